// File: rtl/omsp_atomic_section_ctrl_if.sv
// Signal bundle between the CPU front end and the atomic section controller.
// The master side drives the instruction and status inputs.
// The slave side (the controller) returns the interrupt gating and the
// violation status.
interface omsp_atomic_section_ctrl_if #(
    parameter int CNT_W      = 8,
    parameter int NEST_DEPTH = 2
);
    logic                                  inst_clix;
    logic [CNT_W-1:0]                      clix_len;
    logic                                  enter_sm;
    logic                                  r2_gie;
    logic                                  irq_detect;
    logic                                  viol_clr;
    logic                                  gie;
    logic                                  atom_violation;
    logic                                  viol_sticky;
    logic [1:0]                            viol_cause;
    logic                                  atom_active;
    logic [$clog2(NEST_DEPTH+1)-1:0]       nest_level;
    logic                                  irq_deferred;

    modport master (
        output inst_clix, clix_len, enter_sm, r2_gie, irq_detect, viol_clr,
        input  gie, atom_violation, viol_sticky, viol_cause, atom_active,
               nest_level, irq_deferred
    );

    modport slave (
        input  inst_clix, clix_len, enter_sm, r2_gie, irq_detect, viol_clr,
        output gie, atom_violation, viol_sticky, viol_cause, atom_active,
               nest_level, irq_deferred
    );
endinterface

// File: rtl/omsp_atomic_section_ctrl.sv
// Atomic section controller.
// The controller masks interrupts during:
//   - a clix section, which can be nested up to NEST_DEPTH levels;
//   - a fixed period after secure-module entry.
// It also flags illegal clix and entry requests.
// Optional build macro ATOM_IRQ_DEFER_EN adds the irq_deferred flag.
// This flag records an interrupt that was held off by an active section.
// Without the macro, irq_deferred is tied low.
//
// state | meaning
// IDLE  | no atomic section, interrupts follow r2_gie
// ENTRY | post-SM-entry atomic window, entry counter running
// CLIX  | one or more clix levels active, level counters running
module omsp_atomic_section_ctrl #(
    parameter int CNT_W        = 8,
    parameter int ATOM_BOUND   = 10,
    parameter int ENTRY_PERIOD = 3,
    parameter int NEST_DEPTH   = 2
) (
    input  logic                           mclk,
    input  logic                           puc_rst,
    omsp_atomic_section_ctrl_if.slave      bus
);
    localparam int LW = $clog2(NEST_DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] CLIX  = 2'd2;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_LEN  = 2'd1;
    localparam logic [1:0] CAUSE_NEST = 2'd2;
    localparam logic [1:0] CAUSE_SM   = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] entry_cnt, entry_cnt_nxt;
    logic [CNT_W-1:0] lvl_cnt     [NEST_DEPTH];
    logic [CNT_W-1:0] lvl_cnt_nxt [NEST_DEPTH];
    logic [LW-1:0]    nest_lvl, nest_lvl_nxt;
    logic [CNT_W-1:0] top_cnt;
    logic             len_ok, nest_ok, flush;
    logic             viol_now;
    logic [1:0]       cause_now;
    logic             viol_sticky_q;
    logic [1:0]       viol_cause_q;
    logic             atom_active_int, gie_int;

    // Remaining count of the innermost active clix level, and acceptance checks.
    always_comb begin
        top_cnt = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (int'(nest_lvl) == i + 1) top_cnt = lvl_cnt[i];
        end
        len_ok  = (bus.clix_len <= CNT_W'(ATOM_BOUND));
        nest_ok = (int'(nest_lvl) < NEST_DEPTH) && (bus.clix_len < top_cnt);
    end

    // Violation detection; an early-out in CLIX swallows a coincident clix.
    always_comb begin
        viol_now  = 1'b0;
        cause_now = CAUSE_NONE;
        if (bus.enter_sm) begin
            if (state == ENTRY) begin
                viol_now  = 1'b1;
                cause_now = CAUSE_SM;
            end
        end else if (bus.inst_clix && !(state == CLIX && bus.r2_gie)) begin
            if (!len_ok) begin
                viol_now  = 1'b1;
                cause_now = CAUSE_LEN;
            end else if (state == CLIX && !nest_ok) begin
                viol_now  = 1'b1;
                cause_now = CAUSE_NEST;
            end
        end
    end

    // Next-state, entry counter and clix level stack.
    always_comb begin
        state_nxt     = state;
        entry_cnt_nxt = entry_cnt;
        lvl_cnt_nxt   = lvl_cnt;
        nest_lvl_nxt  = nest_lvl;
        flush         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enter_sm) begin
                    state_nxt     = ENTRY;
                    entry_cnt_nxt = CNT_W'(ENTRY_PERIOD);
                end else if (bus.inst_clix && len_ok) begin
                    state_nxt      = CLIX;
                    lvl_cnt_nxt[0] = bus.clix_len;
                    nest_lvl_nxt   = LW'(1);
                end
            end
            ENTRY: begin
                if (bus.enter_sm) begin
                    state_nxt     = IDLE;
                    entry_cnt_nxt = '0;
                end else if (bus.inst_clix && len_ok) begin
                    state_nxt      = CLIX;
                    entry_cnt_nxt  = '0;
                    lvl_cnt_nxt[0] = bus.clix_len;
                    nest_lvl_nxt   = LW'(1);
                end else if (entry_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    entry_cnt_nxt = entry_cnt - CNT_W'(1);
                end
            end
            CLIX: begin
                if (bus.enter_sm) begin
                    state_nxt     = ENTRY;
                    entry_cnt_nxt = CNT_W'(ENTRY_PERIOD);
                    flush         = 1'b1;
                end else if (bus.r2_gie) begin
                    state_nxt = IDLE;
                    flush     = 1'b1;
                end else begin
                    for (int i = 0; i < NEST_DEPTH; i++) begin
                        if (i < int'(nest_lvl) && lvl_cnt[i] != '0)
                            lvl_cnt_nxt[i] = lvl_cnt[i] - CNT_W'(1);
                    end
                    // Inner levels are always shorter, so level 1 expiring ends everything.
                    if (lvl_cnt[0] == '0) begin
                        state_nxt = IDLE;
                        flush     = 1'b1;
                    end else if (top_cnt == '0) begin
                        nest_lvl_nxt = nest_lvl - LW'(1);
                    end else if (bus.inst_clix && len_ok && nest_ok) begin
                        for (int i = 0; i < NEST_DEPTH; i++) begin
                            if (i == int'(nest_lvl)) lvl_cnt_nxt[i] = bus.clix_len;
                        end
                        nest_lvl_nxt = nest_lvl + LW'(1);
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                entry_cnt_nxt = '0;
                flush         = 1'b1;
            end
        endcase
        if (flush) begin
            for (int i = 0; i < NEST_DEPTH; i++) lvl_cnt_nxt[i] = '0;
            nest_lvl_nxt = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state     <= IDLE;
            entry_cnt <= '0;
            nest_lvl  <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) lvl_cnt[i] <= '0;
        end else begin
            state     <= state_nxt;
            entry_cnt <= entry_cnt_nxt;
            nest_lvl  <= nest_lvl_nxt;
            lvl_cnt   <= lvl_cnt_nxt;
        end
    end

    // Sticky first-violation capture; a new violation beats a coincident clear.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            viol_sticky_q <= 1'b0;
            viol_cause_q  <= CAUSE_NONE;
        end else if (viol_now && (!viol_sticky_q || bus.viol_clr)) begin
            viol_sticky_q <= 1'b1;
            viol_cause_q  <= cause_now;
        end else if (bus.viol_clr) begin
            viol_sticky_q <= 1'b0;
            viol_cause_q  <= CAUSE_NONE;
        end
    end

    assign atom_active_int = (state != IDLE);
    assign gie_int = bus.r2_gie & ~bus.inst_clix & ~bus.enter_sm & ~atom_active_int & ~puc_rst;

    assign bus.gie            = gie_int;
    assign bus.atom_violation = viol_now & ~puc_rst;
    assign bus.viol_sticky    = viol_sticky_q;
    assign bus.viol_cause     = viol_cause_q;
    assign bus.atom_active    = atom_active_int;
    assign bus.nest_level     = nest_lvl;

`ifdef ATOM_IRQ_DEFER_EN
    logic irq_def_q;

    // Remember an interrupt that arrived while a section was holding it off.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst)
            irq_def_q <= 1'b0;
        else if (bus.irq_detect & bus.r2_gie & atom_active_int)
            irq_def_q <= 1'b1;
        else if (gie_int | bus.viol_clr)
            irq_def_q <= 1'b0;
    end

    assign bus.irq_deferred = irq_def_q;
`else
    logic unused_irq_detect;
    assign unused_irq_detect = bus.irq_detect;
    assign bus.irq_deferred  = 1'b0;
`endif
endmodule

// File: tb/tb_omsp_atomic_section_ctrl.sv
// Self-checking bench for omsp_atomic_section_ctrl with default parameters.
// Expected irq_deferred follows whether ATOM_IRQ_DEFER_EN is defined.
module tb_omsp_atomic_section_ctrl;
`ifdef ATOM_IRQ_DEFER_EN
    localparam int DEF = 1;
`else
    localparam int DEF = 0;
`endif

    typedef struct packed {
        logic       clix;
        logic [7:0] len;
        logic       sm;
        logic       g;
        logic       irq;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic       act;
        logic       gie;
        logic [1:0] nest;
        logic       viol;
        logic       sticky;
        logic [1:0] cause;
        logic       irqd;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  e;
    } step_t;

    logic mclk;
    logic puc_rst;
    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    omsp_atomic_section_ctrl_if #(.CNT_W(8), .NEST_DEPTH(2)) bus ();

    omsp_atomic_section_ctrl #(
        .CNT_W(8), .ATOM_BOUND(10), .ENTRY_PERIOD(3), .NEST_DEPTH(2)
    ) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    function automatic step_t mk(int clix, int len, int sm, int g, int irq, int clr,
                                 int act, int nest, int viol, int st, int cause, int irqd);
        step_t t;
        t.s.clix   = 1'(clix);
        t.s.len    = 8'(len);
        t.s.sm     = 1'(sm);
        t.s.g      = 1'(g);
        t.s.irq    = 1'(irq);
        t.s.clr    = 1'(clr);
        t.e.act    = 1'(act);
        t.e.gie    = 1'b0;
        t.e.nest   = 2'(nest);
        t.e.viol   = 1'(viol);
        t.e.sticky = 1'(st);
        t.e.cause  = 2'(cause);
        t.e.irqd   = 1'(irqd);
        return t;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.act    = bus.atom_active;
        o.gie    = bus.gie;
        o.nest   = bus.nest_level;
        o.viol   = bus.atom_violation;
        o.sticky = bus.viol_sticky;
        o.cause  = bus.viol_cause;
        o.irqd   = bus.irq_deferred;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("act=%b gie=%b nest=%0d viol=%b sticky=%b cause=%0d irqd=%b",
                         o.act, o.gie, o.nest, o.viol, o.sticky, o.cause, o.irqd);
    endfunction

    task automatic apply(stim_t s);
        bus.inst_clix  = s.clix;
        bus.clix_len   = s.len;
        bus.enter_sm   = s.sm;
        bus.r2_gie     = s.g;
        bus.irq_detect = s.irq;
        bus.viol_clr   = s.clr;
    endtask

    task automatic test_reset();
        obs_t got, x;
        @(negedge mclk);
        apply(mk(1, 11, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0).s);
        sb.push_back(obs_t'(0));
        #1;
        got = sample();
        x = sb.pop_front();
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL reset_hold got %s exp %s", fmt(got), fmt(x));
        end
        @(negedge mclk);
        puc_rst = 1'b0;
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0).s);
        x = obs_t'(0);
        x.gie = 1'b1;
        sb.push_back(x);
        #1;
        got = sample();
        x = sb.pop_front();
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL reset_release got %s exp %s", fmt(got), fmt(x));
        end
    endtask

    task automatic test_clix_basic();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 6; c++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL clix_basic[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
    endtask

    task automatic test_len_bound();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(1, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        t.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        t.push_back(mk(0, 0,  0, 1, 0, 0, 1, 1, 0, 1, 1, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL len_bound[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
    endtask

    task automatic test_nesting();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(1, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(1, 3,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        t.push_back(mk(1, 1,  0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 2, 0, 1, 2, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 2, 0, 1, 2, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 1, 0, 1, 2, 0));
        t.push_back(mk(1, 11, 0, 0, 0, 0, 1, 1, 1, 1, 2, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 1, 0, 1, 2, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 2, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL nesting[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
    endtask

    task automatic test_entry();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 4; c++) t.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        for (int c = 0; c < 4; c++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL entry[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
    endtask

    task automatic test_early_out();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(1, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL early_out[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
    endtask

    task automatic test_irq_defer();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, DEF));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL irq_defer[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t t[$];
        obs_t  got, x;
        t.push_back(mk(1, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(1, 3,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(1, 11, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        t.push_back(mk(0, 0,  0, 0, 0, 0, 1, 2, 0, 1, 1, 0));
        foreach (t[i]) begin
            @(negedge mclk);
            apply(t[i].s);
            x = t[i].e;
            x.gie = t[i].s.g & ~t[i].s.clix & ~t[i].s.sm & ~x.act;
            sb.push_back(x);
            #1;
            got = sample();
            x = sb.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %s exp %s", i, fmt(got), fmt(x));
            end
        end
        @(negedge mclk);
        #2;
        puc_rst = 1'b1;
        apply(mk(1, 11, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0).s);
        sb.push_back(obs_t'(0));
        #1;
        got = sample();
        x = sb.pop_front();
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL reset_mid_assert got %s exp %s", fmt(got), fmt(x));
        end
        @(negedge mclk);
        puc_rst = 1'b0;
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0).s);
        x = obs_t'(0);
        x.gie = 1'b1;
        sb.push_back(x);
        #1;
        got = sample();
        x = sb.pop_front();
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL reset_mid_release got %s exp %s", fmt(got), fmt(x));
        end
        @(negedge mclk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
    endtask

    initial begin
        puc_rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
        test_reset();
        test_clix_basic();
        test_len_bound();
        test_nesting();
        test_entry();
        test_early_out();
        test_irq_defer();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/omsp_atomic_section_ctrl.md
OMSP_ATOMIC_SECTION_CTRL -- requirements
Module: omsp_atomic_section_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of clix length input and all section counters.
REQ-002 SHALL have parameter ATOM_BOUND, default 10: maximum legal clix length.
REQ-003 SHALL have parameter ENTRY_PERIOD, default 3: atomic cycles granted after SM entry.
REQ-004 SHALL have parameter NEST_DEPTH, default 2 (range 1..4): maximum nested clix levels.
REQ-005 SHALL have port mclk, input, 1: clock.
REQ-006 SHALL have port puc_rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port inst_clix, input, 1: clix instruction executing this cycle.
REQ-008 SHALL have port clix_len, input, CNT_W: requested clix length (r15 low bits).
REQ-009 SHALL have port enter_sm, input, 1: SM entry this cycle.
REQ-010 SHALL have port r2_gie, input, 1: GIE bit from status register.
REQ-011 SHALL have port irq_detect, input, 1: interrupt pending.
REQ-012 SHALL have port viol_clr, input, 1: clears sticky violation state.
REQ-013 SHALL have port gie, output, 1: effective interrupt enable.
REQ-014 SHALL have port atom_violation, output, 1: single-cycle violation pulse.
REQ-015 SHALL have ports viol_sticky (1) and viol_cause (2), outputs: latched first violation and its cause.
REQ-016 SHALL have ports atom_active (1) and nest_level ($clog2(NEST_DEPTH+1)), outputs: section active flag and current clix depth.
REQ-017 SHALL have port irq_deferred, output, 1: an interrupt was held off by an atomic section.

Function
REQ-018 SHALL implement states IDLE, ENTRY, CLIX; atom_active = (state != IDLE).
REQ-019 SHALL, on enter_sm in IDLE or CLIX: discard all clix levels, enter ENTRY, and load the entry counter with ENTRY_PERIOD.
REQ-020 SHALL, in ENTRY, decrement the entry counter each cycle and return to IDLE on the cycle it reads 0.
REQ-021 SHALL, on accepted inst_clix in ENTRY, end the entry period and go to CLIX at level 1.
REQ-022 SHALL treat enter_sm in ENTRY as a violation with cause 3, then go to IDLE with the entry counter cleared.
REQ-023 SHALL accept inst_clix in IDLE or ENTRY when clix_len <= ATOM_BOUND: push level 1, counter = clix_len, state CLIX.
REQ-024 SHALL accept inst_clix in CLIX only if nest_level < NEST_DEPTH and clix_len < top-level remaining count; then push a new level loaded with clix_len.
REQ-025 SHALL decrement every valid level's counter each cycle, pop a level whose counter reads 0, and go to IDLE when level 1 pops.
REQ-026 SHALL pop all levels and go to IDLE when r2_gie = 1 while in CLIX (early-out); this has priority over a same-cycle nested inst_clix, which is then ignored.
REQ-027 SHALL reject inst_clix with clix_len > ATOM_BOUND as cause 1, and a failed nesting check as cause 2; a rejected clix SHALL leave state and counters unchanged.
REQ-028 SHALL pulse atom_violation for exactly the violating cycle, combinationally from the inputs.
REQ-029 SHALL set viol_sticky and capture viol_cause on the first violation only, hold both until viol_clr, and let a violation coincident with viol_clr win.
REQ-030 SHALL drive gie = r2_gie & ~inst_clix & ~enter_sm & ~atom_active.
REQ-031 SHALL use unsigned CNT_W arithmetic with no wrap: counters are never decremented below 0.

Reset
REQ-032 SHALL, on puc_rst at any time including mid-section: state IDLE, all levels invalid, all counters 0, nest_level 0, viol_sticky 0, viol_cause 0, irq_deferred 0.
REQ-033 SHALL drive gie = 0 and atom_violation = 0 while puc_rst is asserted.

Configuration
REQ-034 SHALL, with ATOM_IRQ_DEFER_EN defined: set irq_deferred when irq_detect & r2_gie & atom_active, and clear it on the first cycle gie = 1 or on viol_clr.
REQ-035 SHALL, without ATOM_IRQ_DEFER_EN: tie irq_deferred to 0 and synthesize no deferral logic.

Verification
REQ-036 SHALL test: clix_len=5 in IDLE -> atom_active and gie low for 6 cycles; IDLE on 7th; no violation.
REQ-037 SHALL test: clix_len=11 with ATOM_BOUND=10 -> atom_violation for 1 cycle, viol_cause=1, state stays IDLE.
REQ-038 SHALL test: clix 8, then clix 3 two cycles later -> nest_level=2 for 4 cycles then 1; a third clix -> cause 2.
REQ-039 SHALL test: enter_sm, then enter_sm the next cycle -> cause 3, IDLE; viol_clr -> viol_sticky=0.
REQ-040 SHALL test: clix 9 with r2_gie raised on cycle 3 -> IDLE next cycle, gie=1.
REQ-041 SHALL test: with ATOM_IRQ_DEFER_EN, irq_detect mid-clix -> irq_deferred=1 until gie returns high; puc_rst mid-section -> all outputs at reset values.
